// File: rtl/reg_bus_arb_pkg.sv
// Shared types and constants for the register-bus arbiter slice.
package reg_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_ADDR_W   = 3;
    localparam int DEF_DATA_W   = 2;
    localparam int DEF_READ_LAT = 1;

    // Wait counter must hold READ_LAT-1; sized one step wider so lat=1 still yields a 1-bit counter.
    function automatic int cnt_width(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid request strictly after i_last, wrapping.
module rr_pick
    import reg_bus_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    int unsigned      w_pos32;
    logic [IDX_W-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos32 = 0;
        w_pos   = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            w_pos32 = (32'(i_last) + off) % NUM_REQ;
            w_pos   = IDX_W'(w_pos32);
            if (!o_any && i_req[w_pos]) begin
                o_any          = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
            end
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one register-bank port among NUM_REQ masters.
// Optional grant locking for atomic read-modify-write: define REG_BUS_ARB_LOCK_EN.
module reg_bus_arbiter
    import reg_bus_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int READ_LAT = DEF_READ_LAT
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         REQ_VALID,
    input  logic [NUM_REQ-1:0]         REQ_WRITE,
    input  logic [NUM_REQ*ADDR_W-1:0]  REQ_ADDR,
    input  logic [NUM_REQ*DATA_W-1:0]  REQ_WDATA,
`ifdef REG_BUS_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]         REQ_LOCK,
`endif
    output logic [NUM_REQ-1:0]         REQ_READY,
    output logic [NUM_REQ-1:0]         RSP_VALID,
    output logic [DATA_W-1:0]          RSP_RDATA,
    output logic                       WRITE,
    output logic                       READ,
    output logic [ADDR_W-1:0]          ADDR,
    output logic [DATA_W-1:0]          WRITE_DATA,
    input  logic [DATA_W-1:0]          READ_DATA
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = cnt_width(READ_LAT);

    state_t              r_state;
    state_t              w_next;
    logic [IW-1:0]       r_last;
    logic [CW-1:0]       r_cnt;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;

    logic [NUM_REQ-1:0]  w_pick_req;
    logic [NUM_REQ-1:0]  w_grant;
    logic [IW-1:0]       w_idx;
    logic                w_any;
    logic [NUM_REQ-1:0]  w_last_oh;
    logic                w_sel_wr;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    always_comb begin
        w_last_oh   = '0;
        w_sel_wr    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_last_oh[i] = (r_last == IW'(i));
            if (w_idx == IW'(i)) begin
                w_sel_wr    = REQ_WRITE[i];
                w_sel_addr  = REQ_ADDR[i*ADDR_W +: ADDR_W];
                w_sel_wdata = REQ_WDATA[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef REG_BUS_ARB_LOCK_EN
    logic r_lock;
    logic w_lock_hold;

    // While the holder keeps REQ_LOCK high, only the holder is visible to the picker.
    assign w_lock_hold = r_lock && REQ_LOCK[r_last];
    assign w_pick_req  = w_lock_hold ? (REQ_VALID & w_last_oh) : REQ_VALID;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lock <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_any) begin
                r_lock <= REQ_LOCK[w_idx];
            end else if (!w_lock_hold) begin
                r_lock <= 1'b0;
            end
        end
    end
`else
    assign w_pick_req = REQ_VALID;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_pick (
        .i_req   (w_pick_req),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_next    = r_state;
        REQ_READY = '0;
        case (r_state)
            IDLE: begin
                REQ_READY = w_grant;
                if (w_any) w_next = ISSUE;
            end
            ISSUE:   w_next = WAIT;
            WAIT:    if (r_cnt == '0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_last      <= IW'(NUM_REQ - 1);
            r_cnt       <= '0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_next;
            r_rsp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_wr    <= w_sel_wr;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wr ? w_sel_wdata : '0;
                        r_last  <= w_idx;
                    end
                end
                ISSUE: r_cnt <= CW'(READ_LAT - 1);
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_rsp_valid <= w_last_oh;
                        r_rsp_rdata <= r_wr ? '0 : READ_DATA;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign WRITE      = (r_state == ISSUE) && r_wr;
    assign READ       = (r_state == ISSUE) && !r_wr;
    assign ADDR       = r_addr;
    assign WRITE_DATA = r_wdata;
    assign RSP_VALID  = r_rsp_valid;
    assign RSP_RDATA  = r_rsp_rdata;

endmodule
